// File: rtl/truth_table_checker.sv
// Stimulus/response engine: sweeps every input vector of a combinational gate and checks it against EXPECT.
// Optional first-fail capture is built when CHECKER_FIRST_FAIL_EN is defined.
module truth_table_checker #(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1000,
  parameter int                    SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int            CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  state_t          state_reg, state_next;
  logic [N_IN-1:0] stim_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N_IN:0]   err_reg;

  logic launch, mismatch, last_vec;

  assign launch   = ((state_reg == IDLE) || (state_reg == DONE)) && start;
  assign mismatch = (dut_out != EXPECT[stim_reg]);
  assign last_vec = &stim_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (cnt_reg == '0) state_next = SAMPLE;
      SAMPLE:  state_next = last_vec ? DONE : DRIVE;
      DONE:    if (start) state_next = DRIVE;
      default: state_next = IDLE;
    endcase
  end

  // stim only moves on launch or at the SAMPLE closing edge, so the DUT never sees a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= '0;
    end else if (launch) begin
      stim_reg <= '0;
      cnt_reg  <= RELOAD;
      err_reg  <= '0;
    end else if (state_reg == DRIVE) begin
      if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
    end else if (state_reg == SAMPLE) begin
      if (mismatch) err_reg <= err_reg + 1'b1;
      if (!last_vec) begin
        stim_reg <= stim_reg + 1'b1;
        cnt_reg  <= RELOAD;
      end
    end
  end

`ifdef CHECKER_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_vec_reg;
  logic            ff_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vec_reg   <= '0;
      ff_valid_reg <= 1'b0;
    end else if (launch) begin
      ff_vec_reg   <= '0;
      ff_valid_reg <= 1'b0;
    end else if ((state_reg == SAMPLE) && mismatch && !ff_valid_reg) begin
      ff_vec_reg   <= stim_reg;
      ff_valid_reg <= 1'b1;
    end
  end

  assign first_fail_vec   = ff_vec_reg;
  assign first_fail_valid = ff_valid_reg;
`else
  assign first_fail_vec   = '0;
  assign first_fail_valid = 1'b0;
`endif

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_reg)
      DRIVE, SAMPLE: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (err_reg == '0);
      end
      default: ;
    endcase
  end

  assign stim      = stim_reg;
  assign err_count = err_reg;

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Hardware self-checking stimulus/response engine for combinational gate modules in the logic-gates library. On `start` it drives every input combination onto a DUT and samples the DUT output after a settle interval. It compares each sample against a parameterised expected truth table and reports a pass/fail verdict, a mismatch count and the first failing vector. It is the driving and checking end of a gate's pin interface. It runs on FPGA or in simulation without a behavioural bench.

## Interface
Parameters:
- `N_IN`, 2: number of DUT inputs; legal range 1..6.
- `EXPECT`, 4'b1000: expected truth table, width 2^N_IN. Bit i is the expected DUT output when `stim` = i. The default is AND.
- `SETTLE`, 1: cycles the stimulus is held before sampling; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `stim`  out  N_IN  vector driven to the DUT inputs; bit 0 → `in1`, bit 1 → `in2`, and so on.
- `dut_out`  in  1  DUT output under test.
- `busy`  out  1  run in progress.
- `done`  out  1  level; run finished and results valid.
- `pass`  out  1  valid while `done`; 1 iff `err_count` == 0.
- `err_count`  out  N_IN+1  number of mismatching vectors; saturation is not needed.
- `first_fail_vec`  out  N_IN  first vector that mismatched.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured value.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**: If `start`=1, go to DRIVE. On entry, set `stim`=0, load the settle counter with SETTLE-1, clear `err_count` and `first_fail_*`, and set `busy`=1.
- **DRIVE**: Hold `stim`. If the counter is 0, go to SAMPLE; otherwise decrement it. DRIVE therefore lasts exactly SETTLE cycles.
- **SAMPLE**: Lasts one cycle. At its closing edge, compare `dut_out` with `EXPECT[stim]`.
  - On a mismatch, increment `err_count`. If `first_fail_valid`=0, capture `stim` and set it to 1.
  - If `stim` = 2^N_IN-1, go to DONE.
  - Otherwise increment `stim`, reload the counter and go to DRIVE.
- **DONE**: `busy`=0, `done`=1, `pass`=(`err_count`==0). All results and `stim` hold. If `start`=1, behave exactly as in IDLE; this clears `done` on the same edge.
- `start` is ignored in DRIVE and SAMPLE.
- `stim` is stable from the DRIVE entry edge through the SAMPLE closing edge, so the DUT sees no glitching between samples.
- The mismatch count and first-fail capture both apply on the same SAMPLE edge. Only the first mismatch is ever captured.

## Timing
- Reset values: state IDLE; `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0.
- `rst` takes effect immediately, including mid-run; any partial results are discarded.
- Edge E0 is the edge where `start` is sampled high. After E0, `busy`=1 and `stim`=0.
- Each vector occupies SETTLE+1 cycles.
- `done` rises after edge E0 + 2^N_IN·(SETTLE+1). With the defaults, that is E0+8.
- `pass` and `err_count` are valid in the same cycle that `done` rises.
- `err_count` can be observed incrementing during the run; `pass` is meaningful only while `done`=1.

## Configuration
- `CHECKER_FIRST_FAIL_EN`:
  - Defined: first-fail capture logic is built as described above.
  - Undefined: `first_fail_vec` and `first_fail_valid` are driven constant 0 and no capture registers are built. Verdict, count and timing are unchanged.

## Test plan
- AND DUT, defaults, pulse `start` → `stim` steps 0,1,2,3 every 2 cycles; `done`=1 at E0+8; `pass`=1; `err_count`=0; `first_fail_valid`=0.
- OR DUT with AND `EXPECT`, macro defined → `err_count`=2, `pass`=0, `first_fail_vec`=1, `first_fail_valid`=1.
- `start` held high for the whole run with an AND DUT → a second `start` mid-run has no effect. `done` pulses for one cycle at E0+8, then a new run begins; second-run results again give `pass`=1.
- Assert `rst` while `stim`=2, release, then `start` → all outputs are 0 during reset. The new run completes at its own E0+8 with `pass`=1.
- `SETTLE`=3, N_IN=3, `EXPECT`=8'h80, 3-input AND DUT → `done` at E0+32; `pass`=1; each `stim` value is held for 4 cycles.
- Macro undefined, OR DUT → `err_count`=2, `pass`=0, `first_fail_vec`=0, `first_fail_valid`=0.
